// File: rtl/alu_pkg.sv
// Shared definitions for the wide ALU sequencer and its ALU neighbour.
//   opcode_e      : ALU opcode encoding (4 bits, 0xD-0xF undefined)
//   seq_state_e   : sequencer FSM states
//   IDLE_OP       : opcode driven to the ALU when no slice is in flight
//   is_arith()    : opcode uses/produces a carry chain (ADD, SUB)
//   is_supported(): opcode can be sequenced slice by slice (0..8)
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOT  = 4'h0,
        OP_AND  = 4'h1,
        OP_OR   = 4'h2,
        OP_XOR  = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_NAND = 4'h6,
        OP_NOR  = 4'h7,
        OP_XNOR = 4'h8,
        OP_RSH  = 4'h9,
        OP_LSH  = 4'hA,
        OP_RRO  = 4'hB,
        OP_LRO  = 4'hC
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } seq_state_e;

    localparam logic [3:0] IDLE_OP = 4'hF;

    function automatic logic is_arith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Shifts/rotates move bits across slice boundaries, so they cannot be
    // split into independent slices; only bitwise ops and the carry ops can.
    function automatic logic is_supported(input logic [3:0] op);
        return op <= OP_XNOR;
    endfunction

endpackage

// File: rtl/alu_wide_seq_if.sv
// Bundle of the sequencer's request, response and ALU-side signals.
//   slave  : the sequencer (accepts requests, drives the ALU, returns results)
//   master : the parent (issues requests, hosts the ALU, consumes results)
interface alu_wide_seq_if #(
    parameter int REG_WIDTH  = 8,
    parameter int NUM_SLICES = 4
);
    localparam int W = REG_WIDTH * NUM_SLICES;

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [3:0]           req_instr_i;
    logic [W-1:0]         req_a_i;
    logic [W-1:0]         req_b_i;
    logic                 req_cin_i;

    logic [3:0]           alu_instr_o;
    logic [REG_WIDTH-1:0] alu_a_o;
    logic [REG_WIDTH-1:0] alu_b_o;
    logic                 alu_cin_o;
    logic [REG_WIDTH-1:0] alu_acc_i;
    logic                 alu_cout_i;

    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [W-1:0]         rsp_result_o;
    logic                 rsp_cout_o;
    logic                 rsp_err_o;

    modport slave (
        input  req_valid_i, req_instr_i, req_a_i, req_b_i, req_cin_i,
        output req_ready_o,
        output alu_instr_o, alu_a_o, alu_b_o, alu_cin_o,
        input  alu_acc_i, alu_cout_i,
        output rsp_valid_o, rsp_result_o, rsp_cout_o, rsp_err_o,
        input  rsp_ready_i
    );

    modport master (
        output req_valid_i, req_instr_i, req_a_i, req_b_i, req_cin_i,
        input  req_ready_o,
        input  alu_instr_o, alu_a_o, alu_b_o, alu_cin_o,
        output alu_acc_i, alu_cout_i,
        input  rsp_valid_o, rsp_result_o, rsp_cout_o, rsp_err_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/alu_wide_seq.sv
// Multi-precision sequencer: takes one NUM_SLICES*REG_WIDTH request, feeds
// it to an external combinational ALU one slice per cycle (LSB slice first,
// carry chained through a register) and returns the assembled result.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : alu_wide_seq_if.slave (request, ALU, response channels)
module alu_wide_seq
    import alu_pkg::*;
#(
    parameter int REG_WIDTH  = 8,
    parameter int NUM_SLICES = 4
) (
    input  logic           clk,
    input  logic           reset,
    alu_wide_seq_if.slave  bus
);
    localparam int W  = REG_WIDTH * NUM_SLICES;
    localparam int SW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [SW-1:0] LAST = SW'(NUM_SLICES - 1);

    seq_state_e    state_q;
    logic [SW-1:0] idx_q;
    logic [3:0]    op_q;
    logic [W-1:0]  a_q, b_q, result_q;
    logic          carry_q;
    logic          err_q;
    logic          run;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            op_q     <= IDLE_OP;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        op_q     <= bus.req_instr_i;
                        a_q      <= bus.req_a_i;
                        b_q      <= bus.req_b_i;
                        idx_q    <= '0;
                        result_q <= '0;
                        // carry_q doubles as slice-0 carry-in and, in DONE,
                        // as the final carry-out; forced 0 for non-carry ops.
                        carry_q  <= is_arith(bus.req_instr_i) & bus.req_cin_i;
                        if (is_supported(bus.req_instr_i)) begin
                            err_q   <= 1'b0;
                            state_q <= ST_RUN;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    result_q[int'(idx_q)*REG_WIDTH +: REG_WIDTH] <= bus.alu_acc_i;
                    carry_q <= is_arith(op_q) & bus.alu_cout_i;
                    if (idx_q == LAST) state_q <= ST_DONE;
                    else               idx_q   <= idx_q + SW'(1);
                end
                ST_DONE: begin
                    if (bus.rsp_ready_i) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign run = (state_q == ST_RUN);

    assign bus.req_ready_o  = (state_q == ST_IDLE);
    assign bus.alu_instr_o  = run ? op_q : IDLE_OP;
    assign bus.alu_a_o      = run ? a_q[int'(idx_q)*REG_WIDTH +: REG_WIDTH] : '0;
    assign bus.alu_b_o      = run ? b_q[int'(idx_q)*REG_WIDTH +: REG_WIDTH] : '0;
    assign bus.alu_cin_o    = run & carry_q;

    assign bus.rsp_valid_o  = (state_q == ST_DONE);
    assign bus.rsp_result_o = result_q;
    assign bus.rsp_cout_o   = (state_q == ST_DONE) & carry_q;
    assign bus.rsp_err_o    = err_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
module tb_alu_wide_seq;
    localparam int RW = 8;
    localparam int NS = 4;
    localparam int W  = RW * NS;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_wide_seq_if #(.REG_WIDTH(RW), .NUM_SLICES(NS)) bus ();

    alu_wide_seq #(.REG_WIDTH(RW), .NUM_SLICES(NS)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Stand-in for the parent's real ALU: one combinational slice.
    always_comb begin
        logic [RW:0] s;
        s = '0;
        bus.alu_acc_i  = '0;
        bus.alu_cout_i = 1'b0;
        case (bus.alu_instr_o)
            4'h0: bus.alu_acc_i = ~bus.alu_a_o;
            4'h1: bus.alu_acc_i = bus.alu_a_o & bus.alu_b_o;
            4'h2: bus.alu_acc_i = bus.alu_a_o | bus.alu_b_o;
            4'h3: bus.alu_acc_i = bus.alu_a_o ^ bus.alu_b_o;
            4'h4: begin
                s = {1'b0, bus.alu_a_o} + {1'b0, bus.alu_b_o} + {{RW{1'b0}}, bus.alu_cin_o};
                bus.alu_acc_i = s[RW-1:0]; bus.alu_cout_i = s[RW];
            end
            4'h5: begin
                s = {1'b0, bus.alu_a_o} + {1'b0, ~bus.alu_b_o} + {{RW{1'b0}}, bus.alu_cin_o};
                bus.alu_acc_i = s[RW-1:0]; bus.alu_cout_i = s[RW];
            end
            4'h6: bus.alu_acc_i = ~(bus.alu_a_o & bus.alu_b_o);
            4'h7: bus.alu_acc_i = ~(bus.alu_a_o | bus.alu_b_o);
            4'h8: bus.alu_acc_i = ~(bus.alu_a_o ^ bus.alu_b_o);
            default: ;
        endcase
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Whole-word model: the wide op as plain full-width arithmetic.
    function automatic rsp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        rsp_t r;
        logic [W:0] s;
        r = '0;
        case (op)
            4'h0: r.res = ~a;
            4'h1: r.res = a & b;
            4'h2: r.res = a | b;
            4'h3: r.res = a ^ b;
            4'h4: begin s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin}; r.res = s[W-1:0]; r.cout = s[W]; end
            4'h5: begin s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin}; r.res = s[W-1:0]; r.cout = s[W]; end
            4'h6: r.res = ~(a & b);
            4'h7: r.res = ~(a | b);
            4'h8: r.res = ~(a ^ b);
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    // Carry entering bit RW*k of the full-width add.
    function automatic logic carry_into(input logic [3:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic cin, input int k);
        longint unsigned mask, bb, sum;
        if (op != 4'h4 && op != 4'h5) return 1'b0;
        if (k == 0) return cin;
        mask = (64'd1 << (RW * k)) - 1;
        bb   = (op == 4'h5) ? longint'(~b) : longint'(b);
        sum  = (longint'(a) & mask) + (bb & mask) + longint'(cin);
        return sum[RW * k];
    endfunction

    // Model bookkeeping, advanced on each rising edge.
    int           cyc = 0;
    int           acc_cyc = 0;
    bit           armed = 1'b0;
    bit           pend = 1'b0;
    bit           m_legal = 1'b0;
    logic [3:0]   m_op = '0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic         m_cin = 1'b0;
    rsp_t         m_exp = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            pend  <= 1'b0;
            armed <= 1'b1;
        end else if (armed) begin
            if (pend && bus.rsp_valid_o && bus.rsp_ready_i) begin
                pend <= 1'b0;
            end else if (!pend && bus.req_valid_i && bus.req_ready_o) begin
                pend    <= 1'b1;
                acc_cyc <= cyc + 1;
                m_op    <= bus.req_instr_i;
                m_a     <= bus.req_a_i;
                m_b     <= bus.req_b_i;
                m_cin   <= bus.req_cin_i;
                m_legal <= (bus.req_instr_i <= 4'h8);
                m_exp   <= model(bus.req_instr_i, bus.req_a_i, bus.req_b_i, bus.req_cin_i);
            end
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        int k;
        bit in_run, ev;
        logic [RW-1:0] ea, eb;
        if (armed) begin
            k      = cyc - acc_cyc + 1;
            in_run = pend && m_legal && (k <= NS);
            ev     = pend && (!m_legal || k > NS);
            ea     = in_run ? RW'(m_a >> (RW * (k - 1))) : '0;
            eb     = in_run ? RW'(m_b >> (RW * (k - 1))) : '0;
            chk("rsp_valid", 64'(bus.rsp_valid_o), 64'(ev));
            chk("req_ready", 64'(bus.req_ready_o), 64'(!pend));
            chk("alu_instr", 64'(bus.alu_instr_o), in_run ? 64'(m_op) : 64'hF);
            chk("alu_a", 64'(bus.alu_a_o), 64'(ea));
            chk("alu_b", 64'(bus.alu_b_o), 64'(eb));
            chk("alu_cin", 64'(bus.alu_cin_o),
                in_run ? 64'(carry_into(m_op, m_a, m_b, m_cin, k - 1)) : 64'd0);
            if (ev) begin
                chk("rsp_result", 64'(bus.rsp_result_o), 64'(m_exp.res));
                chk("rsp_cout", 64'(bus.rsp_cout_o), 64'(m_exp.cout));
                chk("rsp_err", 64'(bus.rsp_err_o), 64'(m_exp.err));
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bit got = 1'b0;
        bus.req_valid_i = 1'b1; bus.req_instr_i = op;
        bus.req_a_i = a; bus.req_b_i = b; bus.req_cin_i = cin;
        for (int i = 0; i < 20; i++) begin
            got = bus.req_ready_o;
            @(posedge clk);
            if (got) break;
        end
        #1 bus.req_valid_i = 1'b0;
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic get_rsp(input string nm, input logic [W-1:0] res, input logic cout, input logic err);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid_o) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        if (!seen) begin
            chk({nm, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({nm, "_res"}, 64'(bus.rsp_result_o), 64'(res));
            chk({nm, "_cout"}, 64'(bus.rsp_cout_o), 64'(cout));
            chk({nm, "_err"}, 64'(bus.rsp_err_o), 64'(err));
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready_i = 1'b0;
    endtask

    logic [NS-1:0] cins;
    int            vcount;

    initial begin
        bus.req_valid_i = 1'b0; bus.req_instr_i = '0; bus.req_a_i = '0;
        bus.req_b_i = '0; bus.req_cin_i = 1'b0; bus.rsp_ready_i = 1'b0;

        // Model pins against hand-computed values.
        chk("model_add1", 64'(model(4'h4, 32'h00FFFFFF, 32'h1, 1'b0)), 64'({32'h01000000, 1'b0, 1'b0}));
        chk("model_add2", 64'(model(4'h4, 32'hFFFFFFFF, 32'h1, 1'b0)), 64'({32'h00000000, 1'b1, 1'b0}));
        chk("model_and",  64'(model(4'h1, 32'hF0F01234, 32'h0FF0FF00, 1'b0)), 64'({32'h00F01200, 1'b0, 1'b0}));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("rst_result", 64'(bus.rsp_result_o), 64'd0);
        chk("rst_cout", 64'(bus.rsp_cout_o), 64'd0);
        chk("rst_err", 64'(bus.rsp_err_o), 64'd0);
        chk("rst_alu_instr", 64'(bus.alu_instr_o), 64'hF);
        chk("rst_alu_a", 64'(bus.alu_a_o), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD carry ripple across three slices; valid at cycle 5
        send(4'h4, 32'h00FFFFFF, 32'h00000001, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("add1_latency", 64'(bus.rsp_valid_o), 64'(k == 5));
        end
        get_rsp("add1", 32'h01000000, 1'b0, 1'b0);

        // ADD overflow: carry into slices 1..3 and out
        send(4'h4, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        for (int k = 0; k < NS; k++) begin
            @(negedge clk);
            cins[k] = bus.alu_cin_o;
        end
        chk("add2_cins", 64'(cins), 64'b1110);
        get_rsp("add2", 32'h00000000, 1'b1, 1'b0);

        // AND: no carry anywhere
        send(4'h1, 32'hF0F01234, 32'h0FF0FF00, 1'b1);
        for (int k = 0; k < NS; k++) begin
            @(negedge clk);
            cins[k] = bus.alu_cin_o;
        end
        chk("and_cins", 64'(cins), 64'b0000);
        get_rsp("and", 32'h00F01200, 1'b0, 1'b0);

        // Unsupported opcode
        send(4'h9, 32'h12345678, 32'h1, 1'b1);
        @(negedge clk);
        chk("ill_valid_c1", 64'(bus.rsp_valid_o), 64'd1);
        chk("ill_instr", 64'(bus.alu_instr_o), 64'hF);
        get_rsp("ill", 32'h0, 1'b0, 1'b1);

        // More patterns
        send(4'h5, 32'h00000005, 32'h00000007, 1'b1);
        get_rsp("sub_borrow", 32'hFFFFFFFE, 1'b0, 1'b0);
        send(4'h5, 32'h00000010, 32'h00000001, 1'b1);
        get_rsp("sub", 32'h0000000F, 1'b1, 1'b0);
        send(4'h3, 32'hAAAA5555, 32'hFFFF0000, 1'b0);
        get_rsp("xor", 32'h55555555, 1'b0, 1'b0);
        send(4'h0, 32'h0F0F0F0F, 32'h0, 1'b0);
        get_rsp("not", 32'hF0F0F0F0, 1'b0, 1'b0);
        send(4'hF, 32'h1, 32'h1, 1'b0);
        get_rsp("ill_f", 32'h0, 1'b0, 1'b1);

        // Backpressure then back-to-back
        send(4'h4, 32'h12345678, 32'h11111111, 1'b1);
        for (int i = 0; i < 12 && !bus.rsp_valid_o; i++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_req_ready", 64'(bus.req_ready_o), 64'd0);
            chk("bp_result", 64'(bus.rsp_result_o), 64'h2345678A);
            chk("bp_valid", 64'(bus.rsp_valid_o), 64'd1);
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready_i = 1'b0;
        chk("bp_idle_ready", 64'(bus.req_ready_o), 64'd1);
        send(4'h7, 32'h0, 32'h0, 1'b0);
        get_rsp("b2b_nor", 32'hFFFFFFFF, 1'b0, 1'b0);

        // Reset during slice 2
        send(4'h4, 32'h01020304, 32'h10203040, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_run_instr", 64'(bus.alu_instr_o), 64'h4);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mr_req_ready", 64'(bus.req_ready_o), 64'd1);
        chk("mr_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("mr_result", 64'(bus.rsp_result_o), 64'd0);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) vcount++;
        end
        chk("mr_no_rsp", 64'(vcount), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
